// File: rtl/trigger_pkg.sv
// Shared constants and FSM state type for the trigger event sequencer.
package trigger_pkg;

  // Trigger mode encodings
  localparam logic [1:0] TRG_MODE_OR   = 2'd0;
  localparam logic [1:0] TRG_MODE_AND  = 2'd1;
  localparam logic [1:0] TRG_MODE_MAJ  = 2'd2;
  localparam logic [1:0] TRG_MODE_EDGE = 2'd3;

  // Event FIFO word tags (top two bits of every word)
  localparam logic [1:0] TAG_HDR = 2'b01;
  localparam logic [1:0] TAG_TRL = 2'b10;
  localparam logic [1:0] TAG_ABT = 2'b11;

  // Width of the lost-trigger counter
  localparam int unsigned LOST_W = 16;

  // Event sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_ACQ     = 3'd2,
    ST_TRAILER = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

endpackage

// File: rtl/trigger_condition.sv
// Registers the detect vector, applies the channel mask and evaluates the
// selected trigger mode. Hit and masked pattern are combinational from the
// registered vector so the sequencer can register its response one cycle later.
module trigger_condition
  import trigger_pkg::*;
#(
  parameter int unsigned N_CH = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [1:0]                   i_mode,
  input  logic [N_CH-1:0]              i_mask,
  input  logic [$clog2(N_CH+1)-1:0]    i_coincidence,
  input  logic [N_CH-1:0]              i_detect,
  output logic                         o_hit_c,
  output logic [N_CH-1:0]              o_pattern_c
);

  localparam int unsigned CO_W = $clog2(N_CH + 1);

  logic [N_CH-1:0] r_v_q;
  logic [N_CH-1:0] r_m_prev;
  logic [N_CH-1:0] w_m;
  logic [CO_W-1:0] w_pop;
  logic [CO_W-1:0] w_thr;
  logic            w_hit;

  // Input capture and previous masked pattern for edge detection
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_v_q    <= '0;
      r_m_prev <= '0;
    end else begin
      r_v_q    <= i_detect;
      r_m_prev <= w_m;
    end
  end

  assign w_m = r_v_q & i_mask;

  // Population count of the masked pattern; a zero threshold behaves as one
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      w_pop = w_pop + CO_W'(w_m[i]);
    end
    w_thr = (i_coincidence == '0) ? CO_W'(1) : i_coincidence;
  end

  // Trigger mode selection
  always_comb begin
    w_hit = 1'b0;
    case (i_mode)
      TRG_MODE_OR:   w_hit = |w_m;
      TRG_MODE_AND:  w_hit = (&(w_m | ~i_mask)) && (i_mask != '0);
      TRG_MODE_MAJ:  w_hit = (w_pop >= w_thr);
      TRG_MODE_EDGE: w_hit = |(w_m & ~r_m_prev);
      default:       w_hit = 1'b0;
    endcase
  end

  assign o_hit_c     = w_hit;
  assign o_pattern_c = w_m;

endmodule

// File: rtl/trigger_event_sequencer.sv
// Trigger event sequencer: accepts triggers while armed, gates the sample
// FIFOs for S cycles per event, frames each event into the event FIFO as
// header/trailer (or abort) words and enforces a holdoff after each event.
module trigger_event_sequencer
  import trigger_pkg::*;
#(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 18,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned HOLD_W = 16
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Control_Enable,
  input  logic                         Control_Abort,
  input  logic [1:0]                   Control_Mode,
  input  logic [N_CH-1:0]              Control_Channel_Mask,
  input  logic [$clog2(N_CH+1)-1:0]    Control_Coincidence,
  input  logic [CNT_W-1:0]             Control_Sample_Per_Event,
  input  logic [HOLD_W-1:0]            Control_Holdoff,
  input  logic [N_CH-1:0]              TRG_Detect_Vector,
  input  logic                         FIFO_Event_A_Full,
  output logic                         Control_Trigger_Out,
  output logic                         Control_Busy_Out,
  output logic                         ALL_FIFO_Enable,
  output logic                         FIFO_Event_We,
  output logic [DATA_W-1:0]            FIFO_Event_Data,
  output logic [15:0]                  Lost_Trigger_Count
);

  // Event number fills the header bits left between the tag and the pattern
  localparam int unsigned EV_W = DATA_W - 2 - N_CH;
  localparam int unsigned PL_W = DATA_W - 2;

  logic              w_hit;
  logic [N_CH-1:0]   w_pattern;

  state_t            r_state;
  logic              r_trig;
  logic              r_we;
  logic [DATA_W-1:0] r_data;
  logic              r_fen;
  logic              r_busy;
  logic [LOST_W-1:0] r_lost;
  logic [EV_W-1:0]   r_evnum;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hcnt;
  logic [CNT_W-1:0]  r_s;
  logic [HOLD_W-1:0] r_h;

  state_t            w_state_d;
  logic              w_trig_d;
  logic              w_we_d;
  logic [DATA_W-1:0] w_data_d;
  logic              w_fen_d;
  logic              w_busy_d;
  logic [LOST_W-1:0] w_lost_d;
  logic [EV_W-1:0]   w_evnum_d;
  logic [CNT_W-1:0]  w_cnt_d;
  logic [HOLD_W-1:0] w_hcnt_d;
  logic [CNT_W-1:0]  w_s_d;
  logic [HOLD_W-1:0] w_h_d;

  trigger_condition #(
    .N_CH(N_CH)
  ) u_cond (
    .Clock         (Clock),
    .Reset         (Reset),
    .i_mode        (Control_Mode),
    .i_mask        (Control_Channel_Mask),
    .i_coincidence (Control_Coincidence),
    .i_detect      (TRG_Detect_Vector),
    .o_hit_c       (w_hit),
    .o_pattern_c   (w_pattern)
  );

  // State, counters and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_trig  <= 1'b0;
      r_we    <= 1'b0;
      r_data  <= '0;
      r_fen   <= 1'b0;
      r_busy  <= 1'b0;
      r_lost  <= '0;
      r_evnum <= '0;
      r_cnt   <= '0;
      r_hcnt  <= '0;
      r_s     <= '0;
      r_h     <= '0;
    end else begin
      r_state <= w_state_d;
      r_trig  <= w_trig_d;
      r_we    <= w_we_d;
      r_data  <= w_data_d;
      r_fen   <= w_fen_d;
      r_busy  <= w_busy_d;
      r_lost  <= w_lost_d;
      r_evnum <= w_evnum_d;
      r_cnt   <= w_cnt_d;
      r_hcnt  <= w_hcnt_d;
      r_s     <= w_s_d;
      r_h     <= w_h_d;
    end
  end

  // Next-state and next-output logic; abort always wins over enable and hits.
  // r_cnt counts enable cycles already issued, so it equals samples taken.
  always_comb begin
    w_state_d = r_state;
    w_trig_d  = 1'b0;
    w_we_d    = 1'b0;
    w_data_d  = '0;
    w_fen_d   = 1'b0;
    w_lost_d  = r_lost;
    w_evnum_d = r_evnum;
    w_cnt_d   = r_cnt;
    w_hcnt_d  = r_hcnt;
    w_s_d     = r_s;
    w_h_d     = r_h;

    case (r_state)
      ST_IDLE: begin
        if (Control_Enable && !Control_Abort) begin
          w_state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (Control_Abort || !Control_Enable) begin
          w_state_d = ST_IDLE;
        end else if (w_hit) begin
          if (!FIFO_Event_A_Full) begin
            w_state_d = ST_ACQ;
            w_trig_d  = 1'b1;
            w_we_d    = 1'b1;
            w_data_d  = {TAG_HDR, r_evnum, w_pattern};
            w_s_d     = Control_Sample_Per_Event;
            w_h_d     = Control_Holdoff;
            w_cnt_d   = '0;
          end else if (r_lost != {LOST_W{1'b1}}) begin
            w_lost_d = r_lost + LOST_W'(1);
          end
        end
      end

      ST_ACQ: begin
        if (Control_Abort) begin
          // Event still open: close it with an abort word
          w_state_d = ST_IDLE;
          w_we_d    = 1'b1;
          w_data_d  = {TAG_ABT, PL_W'(r_cnt)};
          w_evnum_d = r_evnum + EV_W'(1);
        end else if (r_cnt != r_s) begin
          w_fen_d = 1'b1;
          w_cnt_d = r_cnt + CNT_W'(1);
        end else begin
          w_state_d = ST_TRAILER;
          w_we_d    = 1'b1;
          w_data_d  = {TAG_TRL, PL_W'(r_s)};
          w_evnum_d = r_evnum + EV_W'(1);
        end
      end

      ST_TRAILER: begin
        // Trailer already written here, so an abort only returns to idle
        if (Control_Abort) begin
          w_state_d = ST_IDLE;
        end else if (r_h == '0) begin
          w_state_d = Control_Enable ? ST_ARMED : ST_IDLE;
        end else begin
          w_state_d = ST_HOLDOFF;
          w_hcnt_d  = '0;
        end
      end

      ST_HOLDOFF: begin
        if (Control_Abort) begin
          w_state_d = ST_IDLE;
        end else if (HOLD_W'(r_hcnt + HOLD_W'(1)) == r_h) begin
          w_state_d = Control_Enable ? ST_ARMED : ST_IDLE;
        end else begin
          w_hcnt_d = r_hcnt + HOLD_W'(1);
        end
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase

    w_busy_d = (w_state_d == ST_ACQ) || (w_state_d == ST_TRAILER) ||
               (w_state_d == ST_HOLDOFF);
  end

  assign Control_Trigger_Out = r_trig;
  assign Control_Busy_Out    = r_busy;
  assign ALL_FIFO_Enable     = r_fen;
  assign FIFO_Event_We       = r_we;
  assign FIFO_Event_Data     = r_data;
  assign Lost_Trigger_Count  = r_lost;

endmodule
